uart_rx_param: RTL and testbench

Parametrised UART receiver for the peripheral subsystem, behind the `UARTrd`/`UARTstat` accumulator-mux path. Oversampled serial input, configurable data width, oversampling ratio and stop-bit count. Adds false-start rejection, optional parity checking, framing-error and break detection, and a post-error recovery state. Feeds the RX FIFO through a single-cycle completion strobe.

---
 rtl/uart_rx_param.sv | 120 ++++++++++++
 tb/tb_uart_rx_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver; define UART_RX_PARITY_EN to build the parity bit check
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sTick,
    input  logic                 rx,
    input  logic                 parityOdd,
    output logic                 rxDoneTick,
    output logic [DATA_BITS-1:0] dOut,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 breakDet,
    output logic                 busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_END = NW'(DATA_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t               state;
    logic [SW-1:0]        s;
    logic [NW-1:0]        n;
    logic                 stop_idx;
    logic                 stop_low;
    logic                 par;
    logic [DATA_BITS-1:0] sr;
    logic                 fe_next;
    logic                 pe_next;
    assign fe_next = stop_low | ~rx;
`ifdef UART_RX_PARITY_EN
    assign pe_next = ^{sr, par, parityOdd};
`else
    logic unused_parity;
    assign unused_parity = parityOdd;
    assign pe_next = 1'b0;
`endif
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        rxDoneTick <= 1'b0;
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            stop_idx  <= 1'b0;
            stop_low  <= 1'b0;
            par       <= 1'b0;
            sr        <= '0;
            dOut      <= '0;
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            breakDet  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!rx) begin
                    state <= START;
                    s     <= '0;
                end
                START: if (sTick) begin
                    if (s != S_MID) s <= s + SW'(1);
                    else if (rx) state <= IDLE;
                    else begin
                        state    <= DATA;
                        s        <= '0;
                        n        <= '0;
                        stop_idx <= 1'b0;
                        stop_low <= 1'b0;
                    end
                end
                DATA: if (sTick) begin
                    if (s != S_END) s <= s + SW'(1);
                    else begin
                        s  <= '0;
                        sr <= {rx, sr[DATA_BITS-1:1]};
                        if (n == N_END) state <= AFTER_DATA;
                        else n <= n + NW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (sTick) begin
                    if (s != S_END) s <= s + SW'(1);
                    else begin
                        s     <= '0;
                        par   <= rx;
                        state <= STOP;
                    end
                end
`endif
                STOP: if (sTick) begin
                    if (s != S_END) s <= s + SW'(1);
                    else if (stop_idx != 1'(STOP_BITS - 1)) begin
                        s        <= '0;
                        stop_idx <= 1'b1;
                        stop_low <= fe_next;
                    end else begin
                        // completion sits mid-way through the last stop bit so the next start edge can resync
                        s          <= '0;
                        rxDoneTick <= 1'b1;
                        dOut       <= sr;
                        frameErr   <= fe_next;
                        parityErr  <= pe_next;
                        breakDet   <= (sr == '0) & ~par & fe_next;
                        state      <= fe_next ? RECOVER : IDLE;
                    end
                end
                RECOVER: if (rx) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: vector table, corner sequences and random frames checked against a frame-level model
module tb_uart_rx_param;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    logic clk = 0, reset = 1, sTick = 0, rx = 1, rx2 = 1, po = 0;
    logic done1, done2, fe1, fe2, pe1, pe2, brk1, brk2, busy1, busy2;
    logic [7:0] dout1;
    logic [6:0] dout2;
    logic prev1 = 0, prev2 = 0;
    int ticks = 0, n_cmp = 0, n_bad = 0;
    int pulses[2];
    int pulse_tick[2];
    typedef struct {
        logic [7:0] data;
        logic pbit;
        logic stop;
        logic podd;
        logic [7:0] exp_d;
        logic exp_fe;
        logic exp_pe;
        logic exp_brk;
    } vec_t;
    vec_t vt[8];

    always #5 clk = ~clk;

    uart_rx_param dut (
        .clk(clk), .reset(reset), .sTick(sTick), .rx(rx), .parityOdd(po),
        .rxDoneTick(done1), .dOut(dout1), .frameErr(fe1), .parityErr(pe1),
        .breakDet(brk1), .busy(busy1)
    );
    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .sTick(sTick), .rx(rx2), .parityOdd(po),
        .rxDoneTick(done2), .dOut(dout2), .frameErr(fe2), .parityErr(pe2),
        .breakDet(brk2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done1) begin
            pulses[0]++;
            pulse_tick[0] = ticks;
            chk("pulse1_width", prev1, 0);
        end
        if (done2) begin
            pulses[1]++;
            pulse_tick[1] = ticks;
            chk("pulse2_width", prev2, 0);
        end
        prev1 = done1;
        prev2 = done2;
    end

    task automatic tick();
        @(negedge clk) sTick = 1;
        ticks++;
        @(negedge clk) sTick = 0;
    endtask

    task automatic drive(input int w, input logic v, input int n);
        if (w == 1) rx2 = v;
        else rx = v;
        repeat (n) tick();
    endtask

    task automatic send(input int w, input logic [8:0] data, input logic pbit, input logic [1:0] stops, input bit short_stop);
        int db = w ? 7 : 8;
        int os = w ? 8 : 16;
        int sb = w ? 2 : 1;
        drive(w, 0, os);
        for (int i = 0; i < db; i++) drive(w, data[i], os);
        if (PAR) drive(w, pbit, os);
        for (int i = 0; i < sb; i++) drive(w, stops[i], (short_stop && i == sb - 1) ? os / 2 : os);
    endtask

    // frame-level reference: results follow from the bits put on the line
    task automatic expect_frame(input string tag, input int w, input logic [8:0] data, input logic pbit,
                                input logic [1:0] stops, input logic podd, input int t0, input int p0);
        int db = w ? 7 : 8;
        int os = w ? 8 : 16;
        int sb = w ? 2 : 1;
        logic [8:0] d = data & ((9'd1 << db) - 9'd1);
        logic fe = !stops[0] || (sb == 2 && !stops[1]);
        logic pe = PAR && ((^d) ^ pbit ^ podd);
        logic brk = (d == 0) && (!PAR || !pbit) && fe;
        int lat = os / 2 + (db + (PAR ? 1 : 0) + sb) * os;
        chk({tag, "_pulses"}, pulses[w] - p0, 1);
        chk({tag, "_latency"}, pulse_tick[w] - t0, lat);
        chk({tag, "_dout"}, w ? {25'd0, dout2} : {24'd0, dout1}, d);
        chk({tag, "_frameErr"}, w ? fe2 : fe1, fe);
        chk({tag, "_parityErr"}, w ? pe2 : pe1, pe);
        chk({tag, "_breakDet"}, w ? brk2 : brk1, brk);
    endtask

    initial begin
        int t0, p0;
        logic [7:0] old;
        logic [8:0] rd;
        logic rp, ro;
        logic [1:0] rs;
        vt[0] = '{8'h55, 0, 1, 0, 8'h55, 0, 0, 0};
        vt[1] = '{8'hA3, 1, 1, 0, 8'hA3, 0, PAR, 0};
        vt[2] = '{8'hA3, 0, 1, 0, 8'hA3, 0, 0, 0};
        vt[3] = '{8'h3C, 0, 0, 0, 8'h3C, 1, 0, 0};
        vt[4] = '{8'h00, 0, 0, 0, 8'h00, 1, 0, 1};
        vt[5] = '{8'h01, 1, 1, 1, 8'h01, 0, PAR, 0};
        vt[6] = '{8'h01, 0, 1, 1, 8'h01, 0, 0, 0};
        vt[7] = '{8'h00, 1, 0, 0, 8'h00, 1, PAR, !PAR};
        repeat (3) @(negedge clk);
        reset = 0;
        chk("rst_done", done1, 0);
        chk("rst_dout", dout1, 0);
        chk("rst_frameErr", fe1, 0);
        chk("rst_parityErr", pe1, 0);
        chk("rst_breakDet", brk1, 0);
        chk("rst_busy", busy1, 0);
        drive(0, 1, 3);
        for (int i = 0; i < 8; i++) begin
            po = vt[i].podd;
            t0 = ticks;
            p0 = pulses[0];
            send(0, {1'b0, vt[i].data}, vt[i].pbit, {1'b1, vt[i].stop}, 0);
            drive(0, 1, 2);
            chk($sformatf("vec%0d_pulses", i), pulses[0] - p0, 1);
            chk($sformatf("vec%0d_latency", i), pulse_tick[0] - t0, PAR ? 168 : 152);
            chk($sformatf("vec%0d_dout", i), dout1, vt[i].exp_d);
            chk($sformatf("vec%0d_frameErr", i), fe1, vt[i].exp_fe);
            chk($sformatf("vec%0d_parityErr", i), pe1, vt[i].exp_pe);
            chk($sformatf("vec%0d_breakDet", i), brk1, vt[i].exp_brk);
            chk($sformatf("vec%0d_busy", i), busy1, 0);
        end
        po = 0;
        t0 = ticks;
        p0 = pulses[0];
        send(0, 9'h55, 0, 2'b11, 0);
        drive(0, 1, 2);
        expect_frame("f55", 0, 9'h55, 0, 2'b11, 0, t0, p0);
        old = dout1;
        p0 = pulses[0];
        drive(0, 0, 4);
        drive(0, 1, 3);
        chk("false_busy_7", busy1, 1);
        tick();
        chk("false_busy_8", busy1, 0);
        drive(0, 1, 20);
        chk("false_pulses", pulses[0] - p0, 0);
        chk("false_dout", dout1, old);
        t0 = ticks;
        p0 = pulses[0];
        send(0, 9'h3C, 0, 2'b00, 0);
        drive(0, 0, 16);
        expect_frame("f3c", 0, 9'h3C, 0, 2'b00, 0, t0, p0);
        chk("recover_busy", busy1, 1);
        @(negedge clk) rx = 1;
        @(negedge clk);
        chk("recover_exit", busy1, 0);
        drive(0, 1, 4);
        t0 = ticks;
        p0 = pulses[0];
        drive(0, 0, 320);
        expect_frame("break", 0, 9'h00, 0, 2'b00, po, t0, p0);
        chk("break_busy", busy1, 1);
        drive(0, 1, 20);
        chk("break_one_frame", pulses[0] - p0, 1);
        chk("break_idle", busy1, 0);
        t0 = ticks;
        p0 = pulses[0];
        send(0, 9'h96, 1, 2'b11, 1);
        expect_frame("b2b_a", 0, 9'h96, 1, 2'b11, po, t0, p0);
        t0 = ticks;
        p0 = pulses[0];
        send(0, 9'h69, 0, 2'b11, 0);
        drive(0, 1, 2);
        expect_frame("b2b_b", 0, 9'h69, 0, 2'b11, po, t0, p0);
        for (int i = 0; i < 30; i++) begin
            rd = 9'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            rs = {1'b1, 1'($urandom_range(0, 3) != 0)};
            po = ro;
            t0 = ticks;
            p0 = pulses[0];
            send(0, rd, rp, rs, 0);
            drive(0, 1, 2);
            expect_frame($sformatf("rnd%0d", i), 0, rd, rp, rs, ro, t0, p0);
        end
        po = 0;
        t0 = ticks;
        p0 = pulses[1];
        send(1, 9'h2A, 1, 2'b11, 0);
        drive(1, 1, 2);
        expect_frame("d7_2a", 1, 9'h2A, 1, 2'b11, 0, t0, p0);
        t0 = ticks;
        p0 = pulses[1];
        send(1, 9'h41, 0, 2'b01, 0);
        drive(1, 1, 2);
        expect_frame("d7_41", 1, 9'h41, 0, 2'b01, 0, t0, p0);
        for (int i = 0; i < 8; i++) begin
            rd = 9'($urandom_range(0, 127));
            rp = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            rs = 2'($urandom_range(0, 3));
            po = ro;
            t0 = ticks;
            p0 = pulses[1];
            send(1, rd, rp, rs, 0);
            drive(1, 1, 2);
            expect_frame($sformatf("rnd7_%0d", i), 1, rd, rp, rs, ro, t0, p0);
        end
        po = 0;
        send(1, 9'h7F, 1, 2'b11, 0);
        drive(1, 1, 2);
        chk("pre_rst_dout2", dout2, 7'h7F);
        p0 = pulses[1];
        drive(1, 0, 8);
        for (int i = 0; i < 3; i++) drive(1, 1, 8);
        drive(1, 1, 4);
        chk("mid_busy2", busy2, 1);
        @(negedge clk) reset = 1;
        @(negedge clk) reset = 0;
        rx2 = 1;
        drive(1, 1, 100);
        chk("midrst_pulses", pulses[1] - p0, 0);
        chk("midrst_dout2", dout2, 0);
        chk("midrst_frameErr2", fe2, 0);
        chk("midrst_parityErr2", pe2, 0);
        chk("midrst_breakDet2", brk2, 0);
        chk("midrst_busy2", busy2, 0);
        chk("midrst_dout1", dout1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
